// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: walks a row-major feature map window by window (stride = POOL)
// and sequences one running-maximum unit through clear / load, then writes each
// pooled result to an output memory under a ready handshake.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             begin one pass (only honoured in IDLE)
//   busy, done        pass in progress / one-cycle completion pulse
//   rdEn, rdAddr      feature-map read strobe and address (data returns next cycle)
//   rdData            feature-map sample, consumed by the maximum unit only
//   maxClear, maxLd   maximum-unit clear and load/compare strobes
//   maxDataOut        registered maximum-unit result
//   wrEn, wrAddr,     output write request, address and data
//   wrData, wrReady   (write accepted when wrEn && wrReady)
module maxpool_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 24,
    parameter int IMG_H      = 24,
    parameter int POOL       = 2,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rdEn,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    input  logic [DATA_WIDTH-1:0] rdData,
    output logic                  maxClear,
    output logic                  maxLd,
    input  logic [DATA_WIDTH-1:0] maxDataOut,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wrReady
);

    localparam int OW = IMG_W / POOL;
    localparam int OH = IMG_H / POOL;

    localparam logic [ADDR_WIDTH-1:0] ZERO_A  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] POOL_A  = ADDR_WIDTH'(POOL);
    localparam logic [ADDR_WIDTH-1:0] POOL_M1 = ADDR_WIDTH'(POOL - 1);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] OW_M1   = ADDR_WIDTH'(OW - 1);
    localparam logic [ADDR_WIDTH-1:0] OH_M1   = ADDR_WIDTH'(OH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   kx_r;
    logic [ADDR_WIDTH-1:0]   ky_r;
    logic [ADDR_WIDTH-1:0]   ox_r;
    logic [ADDR_WIDTH-1:0]   oy_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic                    ld_r;
    logic                    rd_en_s;
    logic                    win_last_s;
    logic                    pass_last_s;
    logic                    rd_data_unused_s;

    // rdData feeds the maximum unit directly; the controller never looks at it.
    assign rd_data_unused_s = ^rdData;

    assign win_last_s  = (kx_r == POOL_M1) && (ky_r == POOL_M1);
    assign pass_last_s = (ox_r == OW_M1) && (oy_r == OH_M1);

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR:  state_nxt_s = ST_READ;
            ST_READ: begin
                if (win_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN:  state_nxt_s = ST_WRITE;
            ST_WRITE: begin
                if (!wrReady) begin
                    state_nxt_s = ST_WRITE;
                end else if (pass_last_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the registered state; maxClear in WRITE fires only on
    // the accept cycle so the unit is cleared at the same edge the write lands.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en_s  = 1'b0;
        maxClear = 1'b0;
        wrEn     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                maxClear = 1'b1;
            end
            ST_READ: begin
                busy    = 1'b1;
                rd_en_s = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                wrEn     = 1'b1;
                maxClear = wrReady;
            end
            ST_FINISH: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rdEn   = rd_en_s;
    assign maxLd  = ld_r;
    assign wrAddr = wr_addr_r;
    assign wrData = maxDataOut;
    // Window origin plus in-window offset; all terms stay inside ADDR_WIDTH.
    assign rdAddr = (oy_r * POOL_A + ky_r) * IMG_W_A + ox_r * POOL_A + kx_r;

    // State register, window/sample counters and the delayed load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            kx_r      <= ZERO_A;
            ky_r      <= ZERO_A;
            ox_r      <= ZERO_A;
            oy_r      <= ZERO_A;
            wr_addr_r <= ZERO_A;
            ld_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // Memory latency is one cycle, so the load strobe trails the read.
            ld_r    <= rd_en_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        kx_r      <= ZERO_A;
                        ky_r      <= ZERO_A;
                        ox_r      <= ZERO_A;
                        oy_r      <= ZERO_A;
                        wr_addr_r <= ZERO_A;
                    end
                end
                ST_READ: begin
                    if (kx_r == POOL_M1) begin
                        kx_r <= ZERO_A;
                        if (ky_r == POOL_M1) begin
                            ky_r <= ZERO_A;
                        end else begin
                            ky_r <= ky_r + ONE_A;
                        end
                    end else begin
                        kx_r <= kx_r + ONE_A;
                    end
                end
                ST_WRITE: begin
                    if (wrReady) begin
                        wr_addr_r <= wr_addr_r + ONE_A;
                        if (ox_r == OW_M1) begin
                            ox_r <= ZERO_A;
                            if (oy_r == OH_M1) begin
                                oy_r <= ZERO_A;
                            end else begin
                                oy_r <= oy_r + ONE_A;
                            end
                        end else begin
                            ox_r <= ox_r + ONE_A;
                        end
                    end
                end
                default: begin
                    kx_r <= kx_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
module tb_maxpool_ctrl;

    localparam int P  = 2;
    localparam int WA = 4;
    localparam int NA = (WA / P) * (WA / P);
    localparam int WB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, rd_en_a, max_clear_a, max_ld_a, wr_en_a, wr_ready_a;
    logic [9:0]  rd_addr_a, wr_addr_a;
    logic [31:0] rd_data_a, max_a, wr_data_a;
    logic        busy_b, done_b, rd_en_b, max_clear_b, max_ld_b, wr_en_b;
    logic        wr_ready_b = 1'b1;
    logic [9:0]  rd_addr_b, wr_addr_b;
    logic [31:0] rd_data_b, max_b, wr_data_b;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [25];

    maxpool_ctrl #(.DATA_WIDTH(32), .IMG_W(WA), .IMG_H(WA), .POOL(P), .ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rdEn(rd_en_a), .rdAddr(rd_addr_a), .rdData(rd_data_a),
        .maxClear(max_clear_a), .maxLd(max_ld_a), .maxDataOut(max_a),
        .wrEn(wr_en_a), .wrAddr(wr_addr_a), .wrData(wr_data_a), .wrReady(wr_ready_a));

    maxpool_ctrl #(.DATA_WIDTH(32), .IMG_W(WB), .IMG_H(WB), .POOL(P), .ADDR_WIDTH(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rdEn(rd_en_b), .rdAddr(rd_addr_b), .rdData(rd_data_b),
        .maxClear(max_clear_b), .maxLd(max_ld_b), .maxDataOut(max_b),
        .wrEn(wr_en_b), .wrAddr(wr_addr_b), .wrData(wr_data_b), .wrReady(wr_ready_b));

    // Feature memories (one-cycle read latency) and signed running-max units.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= (rd_addr_a < 10'd16) ? mem_a[rd_addr_a[3:0]] : 32'h0;
        if (rd_en_b) rd_data_b <= (rd_addr_b < 10'd25) ? mem_b[rd_addr_b[4:0]] : 32'h0;
        if (rst || max_clear_a) max_a <= 32'h8000_0000;
        else if (max_ld_a && ($signed(rd_data_a) > $signed(max_a))) max_a <= rd_data_a;
        if (rst || max_clear_b) max_b <= 32'h8000_0000;
        else if (max_ld_b && ($signed(rd_data_b) > $signed(max_b))) max_b <= rd_data_b;
    end

    int          total = 0, bad = 0;
    int          exp_rd_q[$];
    int          exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    int          exp_done_q[$];
    int          exp_bwa_q[$];
    logic [31:0] exp_bwd_q[$];
    int          s_cyc = 0, clear_cyc = -10, busy_lo = 1, busy_hi = 0, cur_done = 0;
    int          stalls[4];
    int          sink_win = 0, sink_cnt = 0;
    int          rd_cnt_b = 0, wr_cnt_b = 0, done_cnt_b = 0;
    logic        prev_rd = 1'b0, prev_rst = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed maximum over one POOLxPOOL window.
    function automatic logic [31:0] win_max(input bit use_b, input int w, input int ox, input int oy);
        logic signed [31:0] m, v;
        m = 32'sd0;
        for (int ky = 0; ky < P; ky++)
            for (int kx = 0; kx < P; kx++) begin
                int a;
                a = (oy * P + ky) * w + ox * P + kx;
                v = use_b ? mem_b[a] : mem_a[a];
                if ((ky == 0 && kx == 0) || v > m) m = v;
            end
        return m;
    endfunction

    // Issue start on DUT A in the current cycle and queue the whole pass.
    task automatic begin_pass();
        int sum;
        sum = 0;
        start_a = 1'b1;
        s_cyc = cyc;
        clear_cyc = cyc + 1;
        for (int oy = 0; oy < WA / P; oy++)
            for (int ox = 0; ox < WA / P; ox++) begin
                for (int ky = 0; ky < P; ky++)
                    for (int kx = 0; kx < P; kx++)
                        exp_rd_q.push_back((oy * P + ky) * WA + ox * P + kx);
                exp_wa_q.push_back(oy * (WA / P) + ox);
                exp_wd_q.push_back(win_max(1'b0, WA, ox, oy));
            end
        for (int i = 0; i < NA; i++) sum += stalls[i];
        cur_done = s_cyc + 2 + NA * (P * P + 2) + sum;
        busy_lo = s_cyc + 1;
        busy_hi = cur_done - 1;
        exp_done_q.push_back(cur_done);
        sink_win = 0;
        sink_cnt = 0;
    endtask

    task automatic wait_pass_done(input bit pulse);
        int budget;
        budget = 4000;
        tick();
        start_a = 1'b0;
        while (cyc <= cur_done && budget > 0) begin
            start_a = (pulse && cyc < cur_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            budget--;
        end
        start_a = 1'b0;
        if (budget == 0) fail_now("timeout waiting for pass end");
    endtask

    task automatic wait_until(input int target);
        int budget;
        budget = 4000;
        while (cyc < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("wait_target", cyc, target);
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_rden", rd_en_a, 1'b0);
        chk("rst_maxld", max_ld_a, 1'b0);
        chk("rst_maxclear", max_clear_a, 1'b0);
        chk("rst_wren", wr_en_a, 1'b0);
        chk("rst_rdaddr", rd_addr_a, 10'd0);
        chk("rst_wraddr", wr_addr_a, 10'd0);
        chk("rst_wrdata", wr_data_a, max_a);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
    endtask

    // Output sink for DUT A: stalls window k for stalls[k] cycles, then accepts.
    initial begin
        wr_ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (wr_en_a === 1'b1) begin
                if (sink_win < NA && sink_cnt < stalls[sink_win]) begin
                    wr_ready_a = 1'b0;
                    sink_cnt++;
                end else begin
                    wr_ready_a = 1'b1;
                    sink_win++;
                    sink_cnt = 0;
                end
            end else begin
                wr_ready_a = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor for DUT A: pops the scoreboard whenever the DUT presents activity.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy_a, (cyc >= busy_lo) && (cyc <= busy_hi));
            chk("max_ld", max_ld_a, prev_rd && !prev_rst);
            if (rd_en_a) begin
                if (exp_rd_q.size() == 0) fail_now($sformatf("unexpected read addr %0d", rd_addr_a));
                else chk("rd_addr", rd_addr_a, exp_rd_q.pop_front());
            end
            if (wr_en_a) begin
                chk("rd_during_write", rd_en_a, 1'b0);
                chk("clear_on_accept", max_clear_a, wr_ready_a);
                if (exp_wa_q.size() == 0) begin
                    fail_now($sformatf("unexpected write addr %0d", wr_addr_a));
                end else begin
                    chk("wr_addr", wr_addr_a, exp_wa_q[0]);
                    chk("wr_data", wr_data_a, exp_wd_q[0]);
                    if (wr_ready_a) begin
                        void'(exp_wa_q.pop_front());
                        void'(exp_wd_q.pop_front());
                    end
                end
            end else begin
                chk("max_clear", max_clear_a, cyc == clear_cyc);
            end
            if (done_a) begin
                if (exp_done_q.size() == 0) fail_now("unexpected done");
                else chk("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
        prev_rd  <= rd_en_a;
        prev_rst <= rst;
    end

    // Monitor for DUT B (5x5 map): only whole windows may be read.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en_b) begin
                rd_cnt_b <= rd_cnt_b + 1;
                if ((int'(rd_addr_b) % WB) == 4 || int'(rd_addr_b) >= 20)
                    fail_now($sformatf("b read of trailing addr %0d", rd_addr_b));
            end
            if (wr_en_b) begin
                wr_cnt_b <= wr_cnt_b + 1;
                if (exp_bwa_q.size() == 0) begin
                    fail_now("b unexpected write");
                end else begin
                    chk("b_wr_addr", wr_addr_b, exp_bwa_q.pop_front());
                    chk("b_wr_data", wr_data_b, exp_bwd_q.pop_front());
                end
            end
            if (done_b) done_cnt_b <= done_cnt_b + 1;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) stalls[i] = 0;
        for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
        for (int i = 0; i < 25; i++) mem_b[i] = $urandom;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_vals();
        tick();

        // Basic pass on 0..15 (expects (0,5),(1,7),(2,13),(3,15), done at +26),
        // with the 5x5 map running alongside.
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++) begin
                exp_bwa_q.push_back(oy * 2 + ox);
                exp_bwd_q.push_back(win_max(1'b1, WB, ox, oy));
            end
        start_b = 1'b1;
        begin_pass();
        tick();
        start_b = 1'b0;
        start_a = 1'b0;
        wait_pass_done(1'b0);

        // Signed data plus a 3-cycle stall on window 1.
        fill_random();
        mem_a[0] = -32'sd3;
        mem_a[1] = -32'sd8;
        mem_a[4] = -32'sd1;
        mem_a[5] = -32'sd100;
        mem_a[2] = 32'h8000_0000;
        mem_a[3] = 32'h8000_0000;
        mem_a[6] = 32'h8000_0000;
        mem_a[7] = 32'h8000_0000;
        stalls[1] = 3;
        begin_pass();
        // Start in FINISH must be ignored; start in the following IDLE is taken.
        wait_until(cur_done);
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) stalls[i] = $urandom_range(0, 2);
        begin_pass();
        wait_pass_done(1'b1);

        // Reset during READ of window 2, then a fresh basic pass.
        for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
        for (int i = 0; i < 4; i++) stalls[i] = 0;
        tick();
        begin_pass();
        tick();
        start_a = 1'b0;
        wait_until(s_cyc + 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        exp_done_q.delete();
        busy_hi = cyc - 1;
        check_reset_vals();
        repeat (5) tick();
        begin_pass();
        wait_pass_done(1'b0);

        // Randomised passes with backpressure and start pulses while busy.
        for (int n = 0; n < 6; n++) begin
            fill_random();
            for (int i = 0; i < 4; i++) stalls[i] = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) tick();
            begin_pass();
            wait_pass_done(1'b1);
        end

        repeat (4) tick();
        chk("rd_left", exp_rd_q.size(), 0);
        chk("wr_left", exp_wa_q.size(), 0);
        chk("done_left", exp_done_q.size(), 0);
        chk("b_reads", rd_cnt_b, 16);
        chk("b_writes", wr_cnt_b, 4);
        chk("b_done", done_cnt_b, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
